core_branch_predict_unit: RTL and testbench
===========================================

Name: core_branch_predict_unit

Overview:
- Execute-stage branch resolution unit with a parametrised bimodal branch history table (BHT) of saturating counters.
- Gives fetch a direction prediction for the current fetch PC.
- Resolves conditional branches and jumps in EX and compares each outcome against the prediction carried down the pipe.
- Issues a registered one-cycle redirect on misprediction, updates the BHT, and keeps saturating branch and mispredict performance counters.

Parameters:
DATA_WIDTH, 32, width of PC, immediate and operands
BHT_ENTRIES, 64, number of BHT counters; power of two, minimum 2
CNT_WIDTH, 2, saturating counter width; minimum 1
PERF_WIDTH, 32, width of each performance counter
BR_OP_WIDTH, 3, width of branch opcode (`BR_* codes from defines header)

Ports:
clk_i  in  1  core clock
rstn_i  in  1  asynchronous active-low reset
if_pc_i  in  DATA_WIDTH  fetch-stage PC to predict
if_pred_taken_o  out  1  predicted direction for if_pc_i (combinational)
ex_valid_i  in  1  valid instruction in EX
ex_stall_i  in  1  EX held this cycle; no update or resolution
ex_br_op_i  in  BR_OP_WIDTH  `BR_EQ/NE/LT/GE/LTU/GEU; other codes mean not a branch
ex_jump_i  in  1  JAL or JALR in EX
ex_jalr_i  in  1  JALR (valid only with ex_jump_i)
ex_pc_i  in  DATA_WIDTH  PC of EX instruction
ex_imm_i  in  DATA_WIDTH  sign-extended immediate
ex_rs1_i  in  DATA_WIDTH  rs1 operand
ex_rs2_i  in  DATA_WIDTH  rs2 operand
ex_pred_taken_i  in  1  prediction made at fetch for this instruction
redirect_o  out  1  one-cycle pulse: flush and refetch
redirect_pc_o  out  DATA_WIDTH  correct next PC
resolve_valid_o  out  1  one-cycle pulse: a branch or jump was resolved
branch_taken_o  out  1  actual direction of the resolved instruction
perf_clr_i  in  1  synchronous clear of both performance counters
perf_branches_o  out  PERF_WIDTH  conditional branches resolved
perf_mispred_o  out  PERF_WIDTH  redirects issued

Behaviour:
- Reset (asynchronous, any cycle, including mid-update):
  - All BHT counters set to weakly-not-taken: MSB 0, remaining bits 1; value 0 when CNT_WIDTH=1.
  - All registered outputs and both perf counters set to 0.
- Index: IDX_W = log2(BHT_ENTRIES); index = pc[IDX_W+1:2].
- Prediction: if_pred_taken_o = MSB of counter at index(if_pc_i). The read is combinational.
- Accept condition: acc = ex_valid_i & ~ex_stall_i & ~redirect_o.
  - The ~redirect_o term self-squashes the wrong-path instruction sitting in EX during the redirect cycle.
- Comparisons:
  - EQ: rs1==rs2.
  - NE: rs1!=rs2.
  - LT: signed rs1<rs2.
  - GE: NOT LT.
  - LTU: unsigned rs1<rs2.
  - GEU: NOT LTU.
- Classification:
  - is_cond = valid `BR_* code and ~ex_jump_i.
  - taken = 1 for jumps; comparison result for is_cond.
- Target:
  - base = ex_jalr_i ? rs1 : ex_pc_i.
  - tgt = base + imm, modulo 2^DATA_WIDTH (wraps silently).
  - JALR forces tgt[0]=0.
  - Fall-through = ex_pc_i + 4, also wraps.
- Mispredict:
  - is_cond: taken != ex_pred_taken_i.
  - Jump: ~ex_pred_taken_i. Fetch never predicts jumps, so every jump redirects.
- Registered outputs, latched at the clock edge after acc. Latency 1 cycle.
  - resolve_valid_o = acc & (is_cond | ex_jump_i).
  - branch_taken_o = taken.
  - redirect_o = acc & mispredict.
  - redirect_pc_o = taken ? tgt : ex_pc_i+4. It holds its last value when redirect_o=0.
  - Without acc, resolve_valid_o and redirect_o go to 0; other registered outputs hold.
- BHT update on acc & is_cond only:
  - taken: counter increments, saturating at all-ones.
  - not taken: counter decrements, saturating at 0.
  - Jumps and non-branches never write the BHT.
- Same-cycle fetch read and EX write to the same index: fetch sees the old value (read before write); the new value is visible next cycle.
- Perf counters:
  - perf_branches_o += 1 on acc & is_cond.
  - perf_mispred_o += 1 on acc & mispredict.
  - Both saturate at all-ones.
  - perf_clr_i has priority over increment: counter is 0 the next cycle.
- Stall: no BHT write, no counter increment, no pulse. The instruction is resolved on the first non-stalled cycle.

Test Plan:
- Reset, then if_pc_i=0x40 → if_pred_taken_o=0. Counter 1 (CNT_WIDTH=2). All outputs 0.
- BEQ, rs1=rs2=5, pc=0x100, imm=0x20, pred=0 → next cycle redirect_o=1, redirect_pc_o=0x120, resolve_valid_o=1, perf_mispred_o=1. Repeat same BEQ with pred=1 → redirect_o=0, counter saturates at 3.
- BGE rs1=0xFFFFFFFF, rs2=1 → not taken. BGEU same operands → taken. Both with pred=0: BGEU redirect_pc_o=pc+imm, BGE no redirect.
- JALR rs1=0x203, imm=0 → redirect_pc_o=0x202, BHT unchanged. The instruction in EX during the redirect cycle produces no pulse and no update.
- Lookup and update of index 3 in the same cycle → if_pred_taken_o shows the old value, the new value the following cycle. ex_stall_i=1 for 3 cycles → no outputs and no counter change.
- Force perf_mispred_o to all-ones, then another mispredict → stays all-ones. perf_clr_i concurrent with increment → 0. rstn_i low mid-stream → all counters reset to 1 immediately.

Source files
------------

// File: rtl/core_branch_predict_unit_if.sv
// EX-stage resolution bus between the pipeline and core_branch_predict_unit.
// The pipeline side drives the EX instruction and consumes the redirect/resolve pulses.
interface core_branch_predict_unit_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int BR_OP_WIDTH = 3
);
    logic                   ex_valid_i;
    logic                   ex_stall_i;
    logic [BR_OP_WIDTH-1:0] ex_br_op_i;
    logic                   ex_jump_i;
    logic                   ex_jalr_i;
    logic [DATA_WIDTH-1:0]  ex_pc_i;
    logic [DATA_WIDTH-1:0]  ex_imm_i;
    logic [DATA_WIDTH-1:0]  ex_rs1_i;
    logic [DATA_WIDTH-1:0]  ex_rs2_i;
    logic                   ex_pred_taken_i;
    logic                   redirect_o;
    logic [DATA_WIDTH-1:0]  redirect_pc_o;
    logic                   resolve_valid_o;
    logic                   branch_taken_o;

    modport master (
        output ex_valid_i, ex_stall_i, ex_br_op_i, ex_jump_i, ex_jalr_i,
        output ex_pc_i, ex_imm_i, ex_rs1_i, ex_rs2_i, ex_pred_taken_i,
        input  redirect_o, redirect_pc_o, resolve_valid_o, branch_taken_o
    );

    modport slave (
        input  ex_valid_i, ex_stall_i, ex_br_op_i, ex_jump_i, ex_jalr_i,
        input  ex_pc_i, ex_imm_i, ex_rs1_i, ex_rs2_i, ex_pred_taken_i,
        output redirect_o, redirect_pc_o, resolve_valid_o, branch_taken_o
    );
endinterface

// File: rtl/core_branch_predict_unit.sv
// Bimodal branch predictor with EX-stage resolution, registered redirect and
// saturating performance counters.
module core_branch_predict_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_WIDTH   = 2,
    parameter int PERF_WIDTH  = 32,
    parameter int BR_OP_WIDTH = 3
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [DATA_WIDTH-1:0] if_pc_i,
    output logic                  if_pred_taken_o,
    input  logic                  perf_clr_i,
    output logic [PERF_WIDTH-1:0] perf_branches_o,
    output logic [PERF_WIDTH-1:0] perf_mispred_o,
    core_branch_predict_unit_if.slave ex_if
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    localparam logic [BR_OP_WIDTH-1:0] BR_EQ  = BR_OP_WIDTH'(3'd0);
    localparam logic [BR_OP_WIDTH-1:0] BR_NE  = BR_OP_WIDTH'(3'd1);
    localparam logic [BR_OP_WIDTH-1:0] BR_LT  = BR_OP_WIDTH'(3'd4);
    localparam logic [BR_OP_WIDTH-1:0] BR_GE  = BR_OP_WIDTH'(3'd5);
    localparam logic [BR_OP_WIDTH-1:0] BR_LTU = BR_OP_WIDTH'(3'd6);
    localparam logic [BR_OP_WIDTH-1:0] BR_GEU = BR_OP_WIDTH'(3'd7);

    // Weakly-not-taken: MSB clear, all lower bits set (0 for 1-bit counters).
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'((32'd1 << (CNT_WIDTH - 1)) - 32'd1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [PERF_WIDTH-1:0] PERF_MAX = {PERF_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0]  bht_q [BHT_ENTRIES];
    logic [IDX_W-1:0]      if_idx_s;
    logic [IDX_W-1:0]      ex_idx_s;
    logic                  unused_s;

    logic                  acc_s;
    logic                  eq_s;
    logic                  lt_s;
    logic                  ltu_s;
    logic                  cond_op_s;
    logic                  cmp_s;
    logic                  is_cond_s;
    logic                  taken_s;
    logic                  jalr_s;
    logic                  mispred_s;
    logic [DATA_WIDTH-1:0] base_s;
    logic [DATA_WIDTH-1:0] tgt_s;
    logic [DATA_WIDTH-1:0] fall_s;
    logic [CNT_WIDTH-1:0]  cnt_cur_s;
    logic [CNT_WIDTH-1:0]  cnt_nxt_s;
    logic                  bht_we_s;

    logic                  redirect_q,      redirect_d;
    logic [DATA_WIDTH-1:0] redirect_pc_q,   redirect_pc_d;
    logic                  resolve_valid_q, resolve_valid_d;
    logic                  branch_taken_q,  branch_taken_d;
    logic [PERF_WIDTH-1:0] perf_br_q,       perf_br_d;
    logic [PERF_WIDTH-1:0] perf_mp_q,       perf_mp_d;

    assign if_idx_s        = if_pc_i[IDX_W+1:2];
    assign ex_idx_s        = ex_if.ex_pc_i[IDX_W+1:2];
    assign if_pred_taken_o = bht_q[if_idx_s][CNT_WIDTH-1];
    assign unused_s        = ^{if_pc_i[1:0], if_pc_i[DATA_WIDTH-1:IDX_W+2]};

    // Decode, compare, target generation and next-state for all registered state.
    always_comb begin
        acc_s     = ex_if.ex_valid_i & ~ex_if.ex_stall_i & ~redirect_q;
        eq_s      = (ex_if.ex_rs1_i == ex_if.ex_rs2_i);
        lt_s      = ($signed(ex_if.ex_rs1_i) < $signed(ex_if.ex_rs2_i));
        ltu_s     = (ex_if.ex_rs1_i < ex_if.ex_rs2_i);
        cond_op_s = 1'b0;
        cmp_s     = 1'b0;
        case (ex_if.ex_br_op_i)
            BR_EQ:   begin cond_op_s = 1'b1; cmp_s = eq_s;   end
            BR_NE:   begin cond_op_s = 1'b1; cmp_s = ~eq_s;  end
            BR_LT:   begin cond_op_s = 1'b1; cmp_s = lt_s;   end
            BR_GE:   begin cond_op_s = 1'b1; cmp_s = ~lt_s;  end
            BR_LTU:  begin cond_op_s = 1'b1; cmp_s = ltu_s;  end
            BR_GEU:  begin cond_op_s = 1'b1; cmp_s = ~ltu_s; end
            default: begin cond_op_s = 1'b0; cmp_s = 1'b0;   end
        endcase

        is_cond_s = cond_op_s & ~ex_if.ex_jump_i;
        jalr_s    = ex_if.ex_jalr_i & ex_if.ex_jump_i;
        if (ex_if.ex_jump_i) begin
            taken_s   = 1'b1;
            mispred_s = ~ex_if.ex_pred_taken_i;
        end else begin
            taken_s   = is_cond_s & cmp_s;
            mispred_s = is_cond_s & (taken_s ^ ex_if.ex_pred_taken_i);
        end

        base_s = jalr_s ? ex_if.ex_rs1_i : ex_if.ex_pc_i;
        tgt_s  = (base_s + ex_if.ex_imm_i) & ~{{(DATA_WIDTH-1){1'b0}}, jalr_s};
        fall_s = ex_if.ex_pc_i + DATA_WIDTH'(32'd4);

        cnt_cur_s = bht_q[ex_idx_s];
        if (taken_s && (cnt_cur_s != CNT_MAX)) begin
            cnt_nxt_s = cnt_cur_s + CNT_WIDTH'(1'b1);
        end else if (!taken_s && (cnt_cur_s != {CNT_WIDTH{1'b0}})) begin
            cnt_nxt_s = cnt_cur_s - CNT_WIDTH'(1'b1);
        end else begin
            cnt_nxt_s = cnt_cur_s;
        end
        bht_we_s = acc_s & is_cond_s;

        resolve_valid_d = acc_s & (is_cond_s | ex_if.ex_jump_i);
        redirect_d      = acc_s & mispred_s;
        branch_taken_d  = acc_s ? taken_s : branch_taken_q;
        redirect_pc_d   = redirect_d ? (taken_s ? tgt_s : fall_s) : redirect_pc_q;

        // Clear wins over a simultaneous increment.
        if (perf_clr_i) begin
            perf_br_d = {PERF_WIDTH{1'b0}};
            perf_mp_d = {PERF_WIDTH{1'b0}};
        end else begin
            perf_br_d = (bht_we_s && (perf_br_q != PERF_MAX)) ? perf_br_q + PERF_WIDTH'(1'b1) : perf_br_q;
            perf_mp_d = (redirect_d && (perf_mp_q != PERF_MAX)) ? perf_mp_q + PERF_WIDTH'(1'b1) : perf_mp_q;
        end
    end

    // Counter table: reset to weakly-not-taken, written only by resolved conditional branches.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= CNT_INIT;
            end
        end else if (bht_we_s) begin
            bht_q[ex_idx_s] <= cnt_nxt_s;
        end
    end

    // Resolution outputs and performance counters.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            redirect_q      <= 1'b0;
            redirect_pc_q   <= {DATA_WIDTH{1'b0}};
            resolve_valid_q <= 1'b0;
            branch_taken_q  <= 1'b0;
            perf_br_q       <= {PERF_WIDTH{1'b0}};
            perf_mp_q       <= {PERF_WIDTH{1'b0}};
        end else begin
            redirect_q      <= redirect_d;
            redirect_pc_q   <= redirect_pc_d;
            resolve_valid_q <= resolve_valid_d;
            branch_taken_q  <= branch_taken_d;
            perf_br_q       <= perf_br_d;
            perf_mp_q       <= perf_mp_d;
        end
    end

    assign ex_if.redirect_o      = redirect_q;
    assign ex_if.redirect_pc_o   = redirect_pc_q;
    assign ex_if.resolve_valid_o = resolve_valid_q;
    assign ex_if.branch_taken_o  = branch_taken_q;
    assign perf_branches_o       = perf_br_q;
    assign perf_mispred_o        = perf_mp_q;
endmodule

// File: tb/tb_core_branch_predict_unit.sv
// Directed bench for core_branch_predict_unit; 4-bit perf counters make saturation reachable.
module tb_core_branch_predict_unit;
    localparam logic [2:0] EQ  = 3'd0;
    localparam logic [2:0] NE  = 3'd1;
    localparam logic [2:0] NOP = 3'd2;
    localparam logic [2:0] GE  = 3'd5;
    localparam logic [2:0] GEU = 3'd7;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [31:0] if_pc_i = 32'd0;
    logic        if_pred_taken_o;
    logic        perf_clr_i = 1'b0;
    logic [3:0]  perf_branches_o;
    logic [3:0]  perf_mispred_o;
    int          tests_run = 0;
    int          tests_failed = 0;

    core_branch_predict_unit_if #(.DATA_WIDTH(32), .BR_OP_WIDTH(3)) bus ();

    core_branch_predict_unit #(
        .DATA_WIDTH(32), .BHT_ENTRIES(64), .CNT_WIDTH(2), .PERF_WIDTH(4), .BR_OP_WIDTH(3)
    ) dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .if_pc_i         (if_pc_i),
        .if_pred_taken_o (if_pred_taken_o),
        .perf_clr_i      (perf_clr_i),
        .perf_branches_o (perf_branches_o),
        .perf_mispred_o  (perf_mispred_o),
        .ex_if           (bus)
    );

    always #5 clk_i = ~clk_i;

    // {redirect, resolve_valid, branch_taken, redirect_pc, perf_branches, perf_mispred}
    function automatic logic [42:0] obs();
        return {bus.redirect_o, bus.resolve_valid_o, bus.branch_taken_o,
                bus.redirect_pc_o, perf_branches_o, perf_mispred_o};
    endfunction

    task automatic drive(input logic v, input logic [2:0] op, input logic j, input logic jalr,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic pred);
        bus.ex_valid_i = v;   bus.ex_br_op_i = op;   bus.ex_jump_i = j;
        bus.ex_jalr_i = jalr; bus.ex_pc_i = pc;      bus.ex_imm_i = imm;
        bus.ex_rs1_i = rs1;   bus.ex_rs2_i = rs2;    bus.ex_pred_taken_i = pred;
    endtask

    task automatic off();
        drive(1'b0, NOP, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_pc(input logic [31:0] pc);
        if_pc_i = pc;
        #1;
    endtask

    task automatic test_reset();
        off();
        bus.ex_stall_i = 1'b0;
        rstn_i = 1'b0;
        repeat (2) tick();
        @(negedge clk_i);
        rstn_i = 1'b1;
        tick();
        set_pc(32'h40);
        tests_run++;
        if (if_pred_taken_o !== 1'b0) begin
            tests_failed++; $display("FAIL reset_pred: got %b want 0", if_pred_taken_o);
        end
        tests_run++;
        if (obs() !== 43'd0) begin
            tests_failed++; $display("FAIL reset_outputs: got %h want 0", obs());
        end
    endtask

    task automatic test_beq();
        drive(1'b1, EQ, 1'b0, 1'b0, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0);
        tick(); off();
        tests_run++;
        if (obs() !== {3'b111, 32'h120, 4'd1, 4'd1}) begin
            tests_failed++; $display("FAIL beq_mispredict: got %h want %h", obs(), {3'b111, 32'h120, 4'd1, 4'd1});
        end
        set_pc(32'h100);
        tests_run++;
        if (if_pred_taken_o !== 1'b1) begin
            tests_failed++; $display("FAIL beq_bht_inc: got %b want 1", if_pred_taken_o);
        end
        tick();
        tests_run++;
        if (obs() !== {3'b001, 32'h120, 4'd1, 4'd1}) begin
            tests_failed++; $display("FAIL pulse_clear: got %h want %h", obs(), {3'b001, 32'h120, 4'd1, 4'd1});
        end
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, EQ, 1'b0, 1'b0, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1);
            tick(); off();
            tests_run++;
            if (obs() !== {3'b011, 32'h120, 4'(k + 2), 4'd1}) begin
                tests_failed++; $display("FAIL beq_predicted_%0d: got %h want %h", k, obs(), {3'b011, 32'h120, 4'(k + 2), 4'd1});
            end
        end
        // Counter is saturated at 3; one not-taken must leave it at 2 (still predicts taken).
        drive(1'b1, NE, 1'b0, 1'b0, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1);
        tick(); off();
        tests_run++;
        if (obs() !== {3'b110, 32'h104, 4'd4, 4'd2}) begin
            tests_failed++; $display("FAIL bne_fallthrough: got %h want %h", obs(), {3'b110, 32'h104, 4'd4, 4'd2});
        end
        tests_run++;
        if (if_pred_taken_o !== 1'b1) begin
            tests_failed++; $display("FAIL bht_saturate_hi: got %b want 1", if_pred_taken_o);
        end
        tick();
    endtask

    task automatic test_signed_unsigned();
        drive(1'b1, GE, 1'b0, 1'b0, 32'h204, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0);
        tick(); off();
        tests_run++;
        if (obs() !== {3'b010, 32'h104, 4'd5, 4'd2}) begin
            tests_failed++; $display("FAIL bge_signed: got %h want %h", obs(), {3'b010, 32'h104, 4'd5, 4'd2});
        end
        drive(1'b1, GEU, 1'b0, 1'b0, 32'h204, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0);
        tick(); off();
        tests_run++;
        if (obs() !== {3'b111, 32'h244, 4'd6, 4'd3}) begin
            tests_failed++; $display("FAIL bgeu_unsigned: got %h want %h", obs(), {3'b111, 32'h244, 4'd6, 4'd3});
        end
        tick();
    endtask

    task automatic test_jalr_squash();
        drive(1'b1, NOP, 1'b1, 1'b1, 32'h304, 32'h0, 32'h203, 32'h0, 1'b0);
        tick();
        // Wrong-path taken branch at the same index sits in EX during the redirect cycle.
        drive(1'b1, EQ, 1'b0, 1'b0, 32'h304, 32'h10, 32'd5, 32'd5, 1'b0);
        tests_run++;
        if (obs() !== {3'b111, 32'h202, 4'd6, 4'd4}) begin
            tests_failed++; $display("FAIL jalr_target: got %h want %h", obs(), {3'b111, 32'h202, 4'd6, 4'd4});
        end
        tick(); off();
        tests_run++;
        if (obs() !== {3'b001, 32'h202, 4'd6, 4'd4}) begin
            tests_failed++; $display("FAIL squash: got %h want %h", obs(), {3'b001, 32'h202, 4'd6, 4'd4});
        end
        set_pc(32'h304);
        tests_run++;
        if (if_pred_taken_o !== 1'b0) begin
            tests_failed++; $display("FAIL jump_no_bht: got %b want 0", if_pred_taken_o);
        end
    endtask

    task automatic test_same_index();
        set_pc(32'h00C);
        drive(1'b1, EQ, 1'b0, 1'b0, 32'h00C, 32'h10, 32'd5, 32'd5, 1'b0);
        #1;
        tests_run++;
        if (if_pred_taken_o !== 1'b0) begin
            tests_failed++; $display("FAIL rbw_old: got %b want 0", if_pred_taken_o);
        end
        tick(); off();
        tests_run++;
        if (if_pred_taken_o !== 1'b1) begin
            tests_failed++; $display("FAIL rbw_new: got %b want 1", if_pred_taken_o);
        end
        tests_run++;
        if (obs() !== {3'b111, 32'h01C, 4'd7, 4'd5}) begin
            tests_failed++; $display("FAIL idx3_resolve: got %h want %h", obs(), {3'b111, 32'h01C, 4'd7, 4'd5});
        end
        tick();
    endtask

    task automatic test_stall();
        drive(1'b1, NE, 1'b0, 1'b0, 32'h00C, 32'h10, 32'd5, 32'd5, 1'b1);
        bus.ex_stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests_run++;
            if ((obs() !== {3'b001, 32'h01C, 4'd7, 4'd5}) || (if_pred_taken_o !== 1'b1)) begin
                tests_failed++; $display("FAIL stall_%0d: got %h/%b want %h/1", k, obs(), if_pred_taken_o, {3'b001, 32'h01C, 4'd7, 4'd5});
            end
        end
        bus.ex_stall_i = 1'b0;
        tick(); off();
        tests_run++;
        if ((obs() !== {3'b110, 32'h010, 4'd8, 4'd6}) || (if_pred_taken_o !== 1'b0)) begin
            tests_failed++; $display("FAIL stall_release: got %h/%b want %h/0", obs(), if_pred_taken_o, {3'b110, 32'h010, 4'd8, 4'd6});
        end
        tick();
    endtask

    task automatic test_perf_sat();
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, NOP, 1'b1, 1'b0, 32'h400, 32'h8, 32'd0, 32'd0, 1'b0);
            tick(); off(); tick();
        end
        tests_run++;
        if (obs() !== {3'b001, 32'h408, 4'd8, 4'd15}) begin
            tests_failed++; $display("FAIL perf_reach_max: got %h want %h", obs(), {3'b001, 32'h408, 4'd8, 4'd15});
        end
        drive(1'b1, NOP, 1'b1, 1'b0, 32'h400, 32'h8, 32'd0, 32'd0, 1'b0);
        tick(); off();
        tests_run++;
        if (obs() !== {3'b111, 32'h408, 4'd8, 4'd15}) begin
            tests_failed++; $display("FAIL perf_saturate: got %h want %h", obs(), {3'b111, 32'h408, 4'd8, 4'd15});
        end
        tick();
        drive(1'b1, EQ, 1'b0, 1'b0, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0);
        perf_clr_i = 1'b1;
        tick(); off();
        perf_clr_i = 1'b0;
        tests_run++;
        if (obs() !== {3'b111, 32'h120, 4'd0, 4'd0}) begin
            tests_failed++; $display("FAIL perf_clr_priority: got %h want %h", obs(), {3'b111, 32'h120, 4'd0, 4'd0});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        set_pc(32'h100);
        drive(1'b1, EQ, 1'b0, 1'b0, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0);
        tick(); off();
        tests_run++;
        if ((obs() !== {3'b111, 32'h120, 4'd1, 4'd1}) || (if_pred_taken_o !== 1'b1)) begin
            tests_failed++; $display("FAIL pre_reset: got %h/%b want %h/1", obs(), if_pred_taken_o, {3'b111, 32'h120, 4'd1, 4'd1});
        end
        #2;
        rstn_i = 1'b0;
        #1;
        tests_run++;
        if ((obs() !== 43'd0) || (if_pred_taken_o !== 1'b0)) begin
            tests_failed++; $display("FAIL async_reset: got %h/%b want 0/0", obs(), if_pred_taken_o);
        end
        @(negedge clk_i);
        rstn_i = 1'b1;
        tick();
        // From weakly-not-taken one taken update flips the prediction.
        drive(1'b1, EQ, 1'b0, 1'b0, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0);
        tick(); off();
        tests_run++;
        if ((obs() !== {3'b111, 32'h120, 4'd1, 4'd1}) || (if_pred_taken_o !== 1'b1)) begin
            tests_failed++; $display("FAIL post_reset_cnt: got %h/%b want %h/1", obs(), if_pred_taken_o, {3'b111, 32'h120, 4'd1, 4'd1});
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_beq();
        test_signed_unsigned();
        test_jalr_squash();
        test_same_index();
        test_stall();
        test_perf_sat();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
